z80_bus_bridge: RTL

Z80_BUS_BRIDGE -- requirements
Module: z80_bus_bridge

---
 rtl/z80_bus_pkg.sv | 18 +
 rtl/z80_wait_timer.sv | 35 +++
 rtl/z80_bus_bridge.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus bridge.
//   bus_state_e    : bridge FSM states
//   IdleBus        : value driven on D_bus when nothing valid is held (floating-bus look)
//   DefaultTimeout : default maximum wait cycles per downstream access
package z80_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StDone
  } bus_state_e;

  localparam logic [7:0] IdleBus = 8'hFF;

  localparam int unsigned DefaultTimeout = 15;

endpackage

// File: rtl/z80_wait_timer.sv
// Wait-cycle counter for a downstream access.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (asserted on the cycle the access starts)
//   run        : high for every cycle the access is outstanding
//   expired    : high during the TIMEOUT-th running cycle; the count saturates at TIMEOUT
module z80_wait_timer #(
  parameter int unsigned TIMEOUT = z80_bus_pkg::DefaultTimeout
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] Limit = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != Limit)) begin
      count <= count + 1'b1;
    end
  end

  // The count holds the number of completed running cycles, so the cycle in which it
  // would reach TIMEOUT is the last one the access is allowed.
  assign expired = run && (count == Limit - 1'b1);

endmodule

// File: rtl/z80_bus_bridge.sv
// Z80 core bus to single-request memory-side port bridge.
//   CLK, nRESET                    : clock, asynchronous active-low reset
//   nM1 nMREQ nIORQ nRD nWR, A, D_cpu : core strobes (active low), address, write data
//   D_bus, nWAIT                   : read data / interrupt vector to core, wait request
//   mem_req mem_we mem_io mem_addr mem_wdata : downstream request, held for the access
//   mem_ack, mem_rdata             : downstream completion and read data
//   irq, irq_vec, nINT             : interrupt level, IM2 vector, interrupt to core
//   err                            : sticky access-timeout flag
// Optional: define Z80_BRIDGE_IM2_EN to drive nINT from irq and answer acknowledge
// cycles with irq_vec; otherwise nINT stays high and acknowledges read 8'hFF.
module z80_bus_bridge #(
  parameter int unsigned TIMEOUT  = z80_bus_pkg::DefaultTimeout,
  parameter int unsigned IO_SPACE = 1
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        nM1,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic [15:0] A,
  input  logic [7:0]  D_cpu,
  output logic [7:0]  D_bus,
  output logic        nWAIT,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_io,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        irq,
  input  logic [7:0]  irq_vec,
  output logic        nINT,
  output logic        err
);
  import z80_bus_pkg::*;

  bus_state_e state;
  logic       armed;      // strobes seen all-high since the last start; blocks restarts
  logic       abandoned;  // core released the strobes before the ack arrived
  logic       expired;
  logic       in_req;
  logic       strobes_idle;
  logic       mem_cycle;
  logic       io_cycle;
  logic       start;
  logic       inta;

  assign strobes_idle = nRD & nWR & nMREQ & nIORQ;
  // nMREQ wins when both are low.
  assign mem_cycle    = ~nMREQ;
  assign io_cycle     = nMREQ & ~nIORQ & nM1 & (IO_SPACE != 0);
  assign start        = (state == StIdle) && armed && (mem_cycle || io_cycle) && (~nRD || ~nWR);
  assign inta         = (state == StIdle) && armed && ~nM1 && ~nIORQ && nMREQ;
  assign in_req       = (state == StReq);

  // Wait must assert in the very cycle the access is recognised.
  assign nWAIT = ~(in_req || start);

  z80_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (CLK),
    .rst_n  (nRESET),
    .clear  (start),
    .run    (in_req),
    .expired(expired)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= StIdle;
      armed     <= 1'b0;
      abandoned <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_io    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      D_bus     <= IdleBus;
      err       <= 1'b0;
    end else begin
      if (strobes_idle) armed <= 1'b1;
      unique case (state)
        StIdle: begin
          if (start) begin
            state     <= StReq;
            armed     <= 1'b0;
            abandoned <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= ~nWR;
            mem_io    <= nMREQ;
            mem_addr  <= A;
            mem_wdata <= D_cpu;
          end else if (inta) begin
            state <= StHold;
            armed <= 1'b0;
`ifdef Z80_BRIDGE_IM2_EN
            D_bus <= irq_vec;
`else
            D_bus <= IdleBus;
`endif
          end
        end
        StReq: begin
          if (strobes_idle) abandoned <= 1'b1;
          if (mem_ack) begin
            // An ack for a cycle the core already left must not disturb D_bus.
            if (!(abandoned || strobes_idle)) D_bus <= mem_rdata;
            mem_req <= 1'b0;
            state   <= StHold;
          end else if (expired) begin
            D_bus   <= IdleBus;
            err     <= 1'b1;
            mem_req <= 1'b0;
            state   <= StHold;
          end
        end
        StHold: begin
          if (strobes_idle) state <= StDone;
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

`ifdef Z80_BRIDGE_IM2_EN
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      nINT <= 1'b1;
    end else begin
      nINT <= ~irq;
    end
  end
`else
  logic unused_im2;
  assign unused_im2 = ^{irq, irq_vec};
  assign nINT       = 1'b1;
`endif

endmodule
